// File: rtl/bild_scanout.sv
// bild_scanout: VGA scan-out engine. Walks the raster with h/v counters
// advanced by pixel_ce, addresses the framebuffer with 4x replication and
// drives registered RGB332 colour plus syncs, all aligned to one pixel.
module bild_scanout #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SCALE_SHIFT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_ce,
  output logic [7:0] x_data,
  output logic [7:0] y_data,
  input  logic [7:0] pixelData,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       vblank,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [2:0]    r_red;
  logic [2:0]    r_green;
  logic [1:0]    r_blue;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic          r_vblank;
  logic          r_frame_start;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_de;
  logic          w_hsync;
  logic          w_vsync;
  logic          w_vblank;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_de     = (r_h < H_VIS_END) && (r_v < V_VIS_END);
  assign w_hsync  = !((r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END));
  assign w_vsync  = !((r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END));
  assign w_vblank = (r_v >= V_VIS_END);

  // Framebuffer address comes straight from the counters so pixelData is
  // ready to sample on the same edge that advances them.
  assign x_data = 8'(r_h >> SCALE_SHIFT);
  assign y_data = 8'(r_v >> SCALE_SHIFT);

  // Raster position: h wraps at end of line and carries into v.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (pixel_ce) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Output stage: colour and syncs for the current position, one pixel late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_de     <= 1'b0;
      r_vblank <= 1'b0;
    end else if (pixel_ce) begin
      r_red    <= w_de ? pixelData[7:5] : 3'd0;
      r_green  <= w_de ? pixelData[4:2] : 3'd0;
      r_blue   <= w_de ? pixelData[1:0] : 2'd0;
      r_hsync  <= w_hsync;
      r_vsync  <= w_vsync;
      r_de     <= w_de;
      r_vblank <= w_vblank;
    end
  end

  // Frame wrap strobe: single clk wide, cleared on every non-wrap edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= pixel_ce && w_h_last && w_v_last;
    end
  end

  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign vblank      = r_vblank;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_bild_scanout.sv
// Bench for bild_scanout on a shrunken raster (30x19) so whole frames are
// cheap; framebuffer is a behavioural 160x120 array with combinational read.
module tb_bild_scanout;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 30
  localparam int VT = VV + VF + VS + VB;   // 19
  localparam int FT = HT * VT;             // 570

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_ce = 1'b0;
  logic [7:0] x_data, y_data, pixelData;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       hsync, vsync, de, vblank, frame_start;

  logic [7:0] fb [0:19199];

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;   // pixel_ce edges since reset release
  int cnt_de, cnt_hs, cnt_vs, cnt_vb, cnt_fs;

  bild_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SCALE_SHIFT(2)
  ) dut (
    .clk(clk), .reset(reset), .pixel_ce(pixel_ce),
    .x_data(x_data), .y_data(y_data), .pixelData(pixelData),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de), .vblank(vblank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  assign pixelData = (x_data < 8'd160 && y_data < 8'd120) ?
                     fb[int'(y_data) * 160 + int'(x_data)] : 8'h00;

  function automatic logic [7:0] pat(input int x, input int y);
    if (x == 0 && y == 0) return 8'hE0;
    if (x == 1 && y == 0) return 8'h1F;
    return 8'((x * 37 + y * 11 + 5));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (k=%0d t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // Expected outputs after k pixel_ce edges since reset.
  task automatic check_state(input bit fs_exp);
    int n, h, v, nn;
    logic [7:0] pd;
    bit e_de;
    if (k == 0) begin
      chk("rst_red", red, 0);
      chk("rst_green", green, 0);
      chk("rst_blue", blue, 0);
      chk("rst_de", de, 0);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_vblank", vblank, 0);
      chk("rst_x", x_data, 0);
      chk("rst_y", y_data, 0);
    end else begin
      n    = (k - 1) % FT;
      h    = n % HT;
      v    = n / HT;
      e_de = (h < HV) && (v < VV);
      pd   = e_de ? pat(h >> 2, v >> 2) : 8'h00;
      chk("red", red, pd[7:5]);
      chk("green", green, pd[4:2]);
      chk("blue", blue, pd[1:0]);
      chk("de", de, e_de);
      chk("hsync", hsync, !(h >= HV + HF && h < HV + HF + HS));
      chk("vsync", vsync, !(v >= VV + VF && v < VV + VF + VS));
      chk("vblank", vblank, v >= VV);
      nn = k % FT;
      chk("x_data", x_data, (nn % HT) >> 2);
      chk("y_data", y_data, (nn / HT) >> 2);
    end
    chk("frame_start", frame_start, fs_exp);
  endtask

  task automatic step(input bit ce);
    pixel_ce = ce;
    @(posedge clk);
    #1;
    if (ce && !reset) begin
      k++;
      if (de) cnt_de++;
      if (!hsync) cnt_hs++;
      if (!vsync) cnt_vs++;
      if (vblank) cnt_vb++;
    end
    if (frame_start) cnt_fs++;
    check_state(ce && !reset && (k % FT == 0));
  endtask

  task automatic clear_tallies();
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_vb = 0; cnt_fs = 0;
  endtask

  task automatic check_tallies(input string tag);
    chk({tag, "_de_count"}, cnt_de, HV * VV);
    chk({tag, "_hsync_low"}, cnt_hs, HS * VT);
    chk({tag, "_vsync_low"}, cnt_vs, VS * HT);
    chk({tag, "_vblank_hi"}, cnt_vb, (VT - VV) * HT);
    chk({tag, "_frame_start"}, cnt_fs, 1);
  endtask

  initial begin
    int p, l;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        fb[y * 160 + x] = pat(x, y);
    clear_tallies();

    // Held in reset with pixel_ce toggling.
    #1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      step(1'b0);
    end

    // Run part of a line, then reset asynchronously between edges.
    reset = 1'b0;
    for (int i = 0; i < 13; i++) step(1'b1);
    #2;
    reset = 1'b1;
    k = 0;
    #1;
    check_state(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      step(1'b0);
    end
    reset = 1'b0;

    // Full-rate frame with directed pixel-mapping checks.
    clear_tallies();
    for (int i = 0; i < FT; i++) begin
      step(1'b1);
      p = (k - 1) % HT;
      l = (k - 1) / HT;
      if ((l == 0 || l == 3) && p < 8) begin
        chk("map_de", de, 1);
        if (p < 4) begin
          chk("map_red", red, 7);
          chk("map_green", green, 0);
          chk("map_blue", blue, 0);
        end else begin
          chk("map_red", red, 0);
          chk("map_green", green, 7);
          chk("map_blue", blue, 3);
        end
      end
    end
    check_tallies("full");

    // pixel_ce at 1/2 duty.
    clear_tallies();
    for (int i = 0; i < FT; i++) begin
      step(1'b1);
      step(1'b0);
    end
    check_tallies("half");

    // pixel_ce at 1/4 duty.
    clear_tallies();
    for (int i = 0; i < FT; i++) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
      step(1'b0);
    end
    check_tallies("quarter");

    // Reset with the counters at line 7, pixel 10.
    for (int i = 0; i < 7 * HT + 10; i++) step(1'b1);
    chk("pre_rst_y", y_data, 7 >> 2);
    chk("pre_rst_x", x_data, 10 >> 2);
    #2;
    reset = 1'b1;
    k = 0;
    #1;
    check_state(1'b0);
    clear_tallies();
    step(1'b1);
    step(1'b0);
    step(1'b1);
    chk("rst_no_fs", cnt_fs, 0);
    reset = 1'b0;
    clear_tallies();
    for (int i = 0; i < FT; i++) step(1'b1);
    check_tallies("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bild_scanout.md
# bild_scanout

Display scan-out engine for the graphics card. Generates 640x480@60 Hz VGA timing from a single system clock plus a pixel clock enable. Continuously reads the 160x120, 8-bit framebuffer through its read port (`x_data`, `y_data` → `pixelData`) with 4x pixel replication. Drives registered RGB332 colour and sync signals to the DAC/connector; it is the reader for the framebuffer that the GPU writes.

## Interface

Parameters:
- `H_VISIBLE`, default 640: visible pixels per line.
- `H_FRONT`, default 16: horizontal front porch (pixels).
- `H_SYNC`, default 96: hsync pulse width (pixels).
- `H_BACK`, default 48: horizontal back porch (pixels).
- `V_VISIBLE`, default 480: visible lines.
- `V_FRONT`, default 10: vertical front porch (lines).
- `V_SYNC`, default 2: vsync pulse width (lines).
- `V_BACK`, default 33: vertical back porch (lines).
- `SCALE_SHIFT`, default 2: framebuffer coordinate = screen coordinate >> `SCALE_SHIFT`.

Ports:
- `clk`, in, 1: system clock, the same clock as the framebuffer.
- `reset`, in, 1: asynchronous, active-high reset.
- `pixel_ce`, in, 1: pixel clock enable; one pulse per pixel (25 MHz rate).
- `x_data`, out, 8: framebuffer read column.
- `y_data`, out, 8: framebuffer read row.
- `pixelData`, in, 8: framebuffer read data; combinational response to `x_data`/`y_data`.
- `red`, out, 3: colour output.
- `green`, out, 3: colour output.
- `blue`, out, 2: colour output.
- `hsync`, out, 1: horizontal sync, active-low.
- `vsync`, out, 1: vertical sync, active-low.
- `de`, out, 1: data enable; high for visible pixels.
- `vblank`, out, 1: high while the current line is ≥ `V_VISIBLE`.
- `frame_start`, out, 1: one-`clk` pulse at frame wrap.

## Operation

- Counters:
  - `h` counts 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800).
  - `v` counts 0..V_TOTAL-1, where V_TOTAL = 525.
  - Both advance only on a `clk` edge with `pixel_ce`=1.
  - `h` wraps to 0 after H_TOTAL-1; `v` increments on that wrap.
  - `v` wraps to 0 after V_TOTAL-1, coincident with the `h` wrap.
- Address generation is combinational from the counter registers: `x_data` = `h` >> SCALE_SHIFT and `y_data` = `v` >> SCALE_SHIFT, truncated to 8 bits.
  - Maximum values are 199 and 131; no overflow.
  - Out-of-range addresses during blanking are permitted; the framebuffer returns 0 for them.
- Output register stage, updated on a `clk` edge with `pixel_ce`=1, sampling the current `h`, `v` and `pixelData`:
  - `de` = (h < H_VISIBLE) && (v < V_VISIBLE).
  - `red` = pixelData[7:5], `green` = pixelData[4:2], `blue` = pixelData[1:0] when `de` is set; otherwise all zero.
  - `hsync` = 0 iff H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - `vsync` = 0 iff V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - `vblank` = (v ≥ V_VISIBLE).
- `frame_start`: asserted for exactly one `clk` cycle, on the edge where `pixel_ce`=1, `h`=H_TOTAL-1 and `v`=V_TOTAL-1. It is deasserted on every other edge, including edges with `pixel_ce`=0.
- `pixel_ce`=0: counters and all outputs except `frame_start` hold their values.

## Timing

- Reset values (asynchronous, immediate):
  - `h`=0, `v`=0, so `x_data`=0 and `y_data`=0.
  - `red`/`green`/`blue`=0, `de`=0, `vblank`=0, `frame_start`=0.
  - `hsync`=1 and `vsync`=1 (inactive).
- Latency: outputs describing screen pixel (h,v) appear one `pixel_ce` edge after the counters hold (h,v). Colour and syncs are aligned to each other with no skew.
- Framebuffer read path: the `x_data`/`y_data` → `pixelData` combinational path must settle within one `clk` period. The pixel is sampled on the same edge that advances the counters.
- Each framebuffer pixel is replicated over 4 consecutive pixels and 4 consecutive lines.
- Reset deasserted mid-frame: scanning restarts at (0,0) on the first `pixel_ce`. No partial `frame_start` is issued.
- A GPU write to the framebuffer during scan-out is visible on the next read of that address; there is no tearing protection in this block.

## Test plan

- Reset: assert `reset` mid-line with `pixel_ce` toggling. Required: all outputs at their reset values immediately; after release, the first `pixel_ce` edge yields `de`=1 and colour = framebuffer[0,0].
- Pixel mapping: preload framebuffer (0,0)=0xE0 and (1,0)=0x1F. Required:
  - Pixels 0–3 of line 0: `red`=7, `green`=0, `blue`=0.
  - Pixels 4–7: `red`=0, `green`=7, `blue`=3.
  - Same colours repeat on lines 1–3.
- Horizontal timing: count `pixel_ce` edges per line. Required: 800 per line; `de` high for 640; `hsync` low for exactly 96 starting at pixel 656; colour 0 whenever `de`=0.
- Vertical timing: run a full frame. Required: 525 lines; `vsync` low on lines 490–491; `vblank` high on lines 480–524; exactly one `frame_start` pulse, one `clk` wide, coincident with the wrap to (0,0).
- Stall: pixel_ce duty of 1/2 versus 1/4. Required: identical output sequence per `pixel_ce`; outputs stable between enables; `frame_start` still one `clk` wide.
- Reset mid-operation: assert `reset` at line 300, pixel 500. Required: counters return to 0 with no `frame_start`; the next frame timing matches the full-frame scenario.
